// File: rtl/iomem_bridge_master.sv
// -----------------------------------------------------------------------------
// iomem_bridge_master
//   Turns a byte-oriented command stream into single iomem bus transfers.
//   Frames (all multi-byte fields MSB first):
//     write : 0x57, addr[31:0], data[31:0]  -> response 0x06
//     read  : 0x52, addr[31:0]              -> response 0x06, rdata[31:0]
//     bus timeout (either op)               -> response 0x15
//     unknown command byte                  -> response 0x3F
//
// Ports
//   clk, resetn       : clock, asynchronous active-low reset
//   rx_valid, rx_data : one-cycle strobe carrying a received command byte
//   tx_valid, tx_data : response byte, held until tx_ready
//   tx_ready          : response sink accepts tx_data
//   iomem_valid/wstrb/addr/wdata : bus request (wstrb 0 = read)
//   iomem_ready/rdata : bus completion and read data
//   overrun           : sticky, set when a byte arrives in BUS or RESP
// -----------------------------------------------------------------------------
module iomem_bridge_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        iomem_valid,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic        iomem_ready,
    input  logic [31:0] iomem_rdata,
    output logic        overrun
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    // The counter only needs to reach TIMEOUT_CYCLES-1: the abort happens on
    // the edge where it would reach TIMEOUT_CYCLES.
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_is_write;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_valid;
    logic [TW-1:0]   r_tout;
    logic [31:0]     r_rdata;
    logic [2:0]      r_resp_left;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic            r_overrun;

    logic            w_cmd_ok;
    logic            w_last_byte;
    logic            w_tx_fire;
    logic            w_timeout;

    assign w_cmd_ok    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
    assign w_last_byte = rx_valid && (r_byte_cnt == 2'd3);
    assign w_tx_fire   = r_tx_valid && tx_ready;
    // Ready in the final counted cycle wins over the timeout.
    assign w_timeout   = !iomem_ready && (r_tout == TOUT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (rx_valid)    w_state_next = w_cmd_ok ? ADDR : RESP;
            ADDR: if (w_last_byte) w_state_next = r_is_write ? DATA : BUS;
            DATA: if (w_last_byte) w_state_next = BUS;
            BUS:  if (iomem_ready || w_timeout) w_state_next = RESP;
            RESP: if (w_tx_fire && (r_resp_left == 3'd0)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_write  <= 1'b0;
            r_byte_cnt  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_valid     <= 1'b0;
            r_tout      <= '0;
            r_rdata     <= '0;
            r_resp_left <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (rx_valid && ((r_state == BUS) || (r_state == RESP)))
                r_overrun <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        if (w_cmd_ok) begin
                            r_is_write <= (rx_data == CMD_WRITE);
                            r_byte_cnt <= '0;
                        end else begin
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= RSP_ERR;
                            r_resp_left <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        r_addr     <= {r_addr[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte && !r_is_write) begin
                            r_valid <= 1'b1;
                            r_tout  <= '0;
                            r_wstrb <= 4'h0;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        r_wdata    <= {r_wdata[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_valid <= 1'b1;
                            r_tout  <= '0;
                            r_wstrb <= 4'hF;
                        end
                    end
                end
                BUS: begin
                    if (iomem_ready) begin
                        r_valid     <= 1'b0;
                        r_rdata     <= iomem_rdata;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= RSP_ACK;
                        r_resp_left <= r_is_write ? 3'd0 : 3'd4;
                    end else if (w_timeout) begin
                        r_valid     <= 1'b0;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= RSP_NAK;
                        r_resp_left <= '0;
                    end else begin
                        r_tout <= r_tout + TW'(1);
                    end
                end
                RESP: begin
                    if (w_tx_fire) begin
                        if (r_resp_left == 3'd0) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            // Read data drains MSB first through the top byte.
                            r_tx_data   <= r_rdata[31:24];
                            r_rdata     <= {r_rdata[23:0], 8'h00};
                            r_resp_left <= r_resp_left - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign iomem_valid = r_valid;
    assign iomem_wstrb = r_wstrb;
    assign iomem_addr  = r_addr;
    assign iomem_wdata = r_wdata;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_iomem_bridge_master.sv
// -----------------------------------------------------------------------------
// tb_iomem_bridge_master
//   Self-checking bench for iomem_bridge_master (TIMEOUT_CYCLES = 8).
//   A hand-filled vector table, directed multi-cycle sequences and random
//   frames checked against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_iomem_bridge_master;

    localparam int TOUT = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        overrun;

    iomem_bridge_master #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ntx;
        logic [39:0] tx;       // response bytes, first byte in [39:32]
        int          vrises;
        int          hs;
        int          vcycles;
        logic [3:0]  wstrb;
    } exp_t;

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;      // valid cycles before ready; >= TOUT means never
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Responder / tx sink configuration
    int          ready_lat = 0;
    logic [31:0] rdata_cfg = '0;
    int          vcnt = 0;
    bit          tx_manual = 0;
    bit          tx_rand = 0;
    bit          exp_overrun = 0;

    // Monitor observations
    logic [7:0]  txq[$];
    int          vrises = 0;
    int          hs = 0;
    int          vcycles = 0;
    logic [31:0] rec_addr, rec_wdata;
    logic [3:0]  rec_wstrb;
    bit          prev_v = 0;
    bit          prev_stall = 0;
    logic [7:0]  held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: ready after ready_lat valid cycles, junk rdata otherwise.
    always @(negedge clk) begin
        if (!iomem_valid) begin
            vcnt = 0;
            iomem_ready = 1'b0;
        end else begin
            iomem_ready = (vcnt == ready_lat);
            iomem_rdata = (vcnt == ready_lat) ? rdata_cfg : $urandom();
            vcnt++;
        end
    end

    always @(negedge clk)
        if (!tx_manual) tx_ready = tx_rand ? ($urandom_range(0, 3) != 0) : 1'b1;

    // Monitor samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!resetn) begin
            prev_v = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, held);
            end
            prev_stall = tx_valid && !tx_ready;
            held = tx_data;
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (iomem_valid) begin
                vcycles++;
                if (!prev_v) begin
                    vrises++;
                    rec_addr = iomem_addr;
                    rec_wdata = iomem_wdata;
                    rec_wstrb = iomem_wstrb;
                end else begin
                    chk("bus_stable_addr", iomem_addr, rec_addr);
                    chk("bus_stable_wdata", iomem_wdata, rec_wdata);
                    chk("bus_stable_wstrb", iomem_wstrb, rec_wstrb);
                end
                if (iomem_ready) hs++;
            end
            prev_v = iomem_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mke(int ntx, logic [39:0] tx, int vr, int h, int vc, logic [3:0] ws);
        exp_t e;
        e.ntx = ntx; e.tx = tx; e.vrises = vr; e.hs = h; e.vcycles = vc; e.wstrb = ws;
        return e;
    endfunction

    function automatic vec_t mkv(string n, logic [7:0] cmd, logic [31:0] addr, logic [31:0] wd,
                                 int lat, logic [31:0] rd, exp_t e);
        vec_t v;
        v.name = n; v.cmd = cmd; v.addr = addr; v.wdata = wd; v.lat = lat; v.rdata = rd; v.e = e;
        return v;
    endfunction

    // Frame-level reference: what one frame should produce on tx and on the bus.
    function automatic exp_t model(input logic [7:0] cmd, input int lat, input logic [31:0] rd);
        exp_t e;
        bit ok;
        if (cmd != 8'h57 && cmd != 8'h52) return mke(1, {8'h3F, 32'h0}, 0, 0, 0, 4'h0);
        ok = (lat < TOUT);
        e.vrises  = 1;
        e.hs      = ok ? 1 : 0;
        e.vcycles = ok ? lat + 1 : TOUT;
        e.wstrb   = (cmd == 8'h57) ? 4'hF : 4'h0;
        if (!ok)                 begin e.ntx = 1; e.tx = {8'h15, 32'h0}; end
        else if (cmd == 8'h57)   begin e.ntx = 1; e.tx = {8'h06, 32'h0}; end
        else                     begin e.ntx = 5; e.tx = {8'h06, rd};    end
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'($urandom());
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                               input int lat, input logic [31:0] rd, input int gap_max);
        logic [63:0] body;
        int nb;
        txq.delete();
        vrises = 0; hs = 0; vcycles = 0;
        ready_lat = lat;
        rdata_cfg = rd;
        body = {addr, wd};
        nb = (cmd == 8'h57) ? 8 : (cmd == 8'h52) ? 4 : 0;
        send_byte(cmd);
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(body[63 - 8*i -: 8]);
        end
    endtask

    task automatic finish_frame(input string name, input logic [31:0] addr, input logic [31:0] wd,
                                input exp_t e);
        int n = 0;
        while (txq.size() < e.ntx && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, ".ntx"}, txq.size(), e.ntx);
        for (int i = 0; i < e.ntx && i < txq.size(); i++)
            chk($sformatf("%s.tx%0d", name, i), txq[i], e.tx[39 - 8*i -: 8]);
        chk({name, ".vrises"}, vrises, e.vrises);
        chk({name, ".handshakes"}, hs, e.hs);
        chk({name, ".vcycles"}, vcycles, e.vcycles);
        if (e.vrises > 0) begin
            chk({name, ".wstrb"}, rec_wstrb, e.wstrb);
            chk({name, ".addr"}, rec_addr, addr);
            if (e.wstrb == 4'hF) chk({name, ".wdata"}, rec_wdata, wd);
        end
        chk({name, ".overrun"}, overrun, exp_overrun);
    endtask

    task automatic run_frame(input vec_t v, input int gap_max);
        start_frame(v.cmd, v.addr, v.wdata, v.lat, v.rdata, gap_max);
        finish_frame(v.name, v.addr, v.wdata, v.e);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = mkv("wr_basic", 8'h57, 32'h0500_0010, 32'hDEAD_BEEF, 2, 32'h0,
                     mke(1, 40'h06_0000_0000, 1, 1, 3, 4'hF));
        tbl[1] = mkv("rd_basic", 8'h52, 32'h0300_0004, 32'h0, 0, 32'h1234_5678,
                     mke(5, 40'h06_1234_5678, 1, 1, 1, 4'h0));
        tbl[2] = mkv("rd_timeout", 8'h52, 32'h0000_0000, 32'h0, 99, 32'h0,
                     mke(1, 40'h15_0000_0000, 1, 0, 8, 4'h0));
        tbl[3] = mkv("rd_ready_last", 8'h52, 32'h8000_0001, 32'h0, 7, 32'hA5C3_0F01,
                     mke(5, 40'h06_A5C3_0F01, 1, 1, 8, 4'h0));
        tbl[4] = mkv("wr_timeout", 8'h57, 32'h0000_0003, 32'h1122_3344, 8, 32'h0,
                     mke(1, 40'h15_0000_0000, 1, 0, 8, 4'hF));
        tbl[5] = mkv("unknown_cmd", 8'h41, 32'h0, 32'h0, 0, 32'h0,
                     mke(1, 40'h3F_0000_0000, 0, 0, 0, 4'h0));
        tbl[6] = mkv("wr_ready_last", 8'h57, 32'hFFFF_FFFF, 32'h0000_0000, 7, 32'h0,
                     mke(1, 40'h06_0000_0000, 1, 1, 8, 4'hF));
        tbl[7] = mkv("rd_lat6", 8'h52, 32'h0000_0002, 32'h0, 6, 32'hFFFF_FFFF,
                     mke(5, 40'h06_FFFF_FFFF, 1, 1, 7, 4'h0));

        resetn = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        tx_ready = 1'b1;
        iomem_ready = 1'b0;
        iomem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.iomem_valid", iomem_valid, 0);
        chk("rst.tx_valid", tx_valid, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.wstrb", iomem_wstrb, 0);
        chk("rst.addr", iomem_addr, 0);
        chk("rst.wdata", iomem_wdata, 0);
        chk("rst.tx_data", tx_data, 0);

        // First frame byte goes in on the very first edge after release.
        resetn = 1'b1;
        foreach (tbl[i]) run_frame(tbl[i], 0);

        // Read with a 3-cycle tx stall in the middle of the data bytes.
        tx_manual = 1;
        tx_ready = 1'b1;
        start_frame(8'h52, 32'h0300_0004, 32'h0, 1, 32'h1234_5678, 0);
        for (int n = 0; txq.size() < 2 && n < 100; n++) @(negedge clk);
        tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall.tx_valid", tx_valid, 1);
            chk("stall.tx_data", tx_data, 8'h34);
        end
        tx_ready = 1'b1;
        finish_frame("rd_stall", 32'h0300_0004, 32'h0, mke(5, 40'h06_1234_5678, 1, 1, 2, 4'h0));
        tx_manual = 0;

        // Byte arriving while the bus request is pending is dropped.
        start_frame(8'h52, 32'h0000_0100, 32'h0, 4, 32'hCAFE_F00D, 0);
        chk("ovr.in_bus", iomem_valid, 1);
        send_byte(8'h57);
        exp_overrun = 1;
        finish_frame("ovr_frame", 32'h0000_0100, 32'h0, mke(5, 40'h06_CAFE_F00D, 1, 1, 5, 4'h0));
        run_frame(mkv("ovr_next", 8'h57, 32'h0000_0200, 32'h5555_AAAA, 1, 32'h0,
                      mke(1, 40'h06_0000_0000, 1, 1, 2, 4'hF)), 0);

        // Reset while the bus request is pending.
        start_frame(8'h52, 32'h0000_0300, 32'h0, 99, 32'h0, 0);
        chk("rstbus.pre_valid", iomem_valid, 1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rstbus.iomem_valid", iomem_valid, 0);
        chk("rstbus.tx_valid", tx_valid, 0);
        chk("rstbus.overrun", overrun, 0);
        chk("rstbus.wstrb", iomem_wstrb, 0);
        chk("rstbus.addr", iomem_addr, 0);
        chk("rstbus.tx_data", tx_data, 0);
        exp_overrun = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        // Any stray response from the aborted frame would show up here.
        run_frame(mkv("after_rst", 8'h57, 32'h0000_0400, 32'h0BAD_F00D, 0, 32'h0,
                      mke(1, 40'h06_0000_0000, 1, 1, 1, 4'hF)), 0);

        // Random frames with gaps and tx back-pressure.
        tx_rand = 1;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      v.cmd = 8'h57;
            else if (r < 8) v.cmd = 8'h52;
            else begin
                v.cmd = 8'($urandom_range(0, 255));
                while (v.cmd == 8'h57 || v.cmd == 8'h52) v.cmd = 8'($urandom_range(0, 255));
            end
            v.name  = $sformatf("rnd%0d", i);
            v.addr  = $urandom();
            v.wdata = $urandom();
            v.lat   = $urandom_range(0, 10);
            v.rdata = $urandom();
            v.e     = model(v.cmd, v.lat, v.rdata);
            run_frame(v, 2);
        end
        tx_rand = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iomem_bridge_master.md
IOMEM_BRIDGE_MASTER -- requirements
Module: iomem_bridge_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles iomem_valid waits for iomem_ready before abort.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received command byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 tx_valid  output  1  response byte available.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_ready  input  1  sink accepts tx_data; transfer when tx_valid && tx_ready.
REQ-009 iomem_valid  output  1  bus request to peripheral bus.
REQ-010 iomem_wstrb  output  4  byte write strobes; 4'h0 = read.
REQ-011 iomem_addr  output  32  bus address.
REQ-012 iomem_wdata  output  32  write data.
REQ-013 iomem_ready  input  1  responder completes transfer.
REQ-014 iomem_rdata  input  32  read data, valid when iomem_ready high.
REQ-015 overrun  output  1  sticky: rx byte dropped.

Function
REQ-016 Block SHALL be an iomem initiator driven by a byte command stream; frames: write = 0x57, addr[31:0] 4 bytes MSB first, data[31:0] 4 bytes MSB first; read = 0x52, addr 4 bytes MSB first.
REQ-017 FSM states SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-018 IDLE: rx 0x57 or 0x52 -> ADDR, latch op, byte count 0; any other byte -> RESP with single response 0x3F.
REQ-019 ADDR: shift each rx byte into address; after 4th byte -> DATA if write, else BUS.
REQ-020 DATA: shift rx bytes into wdata; after 4th byte -> BUS.
REQ-021 iomem_valid SHALL assert the cycle after the last frame byte is accepted; wstrb 4'hF for write, 4'h0 for read.
REQ-022 iomem_addr, iomem_wdata, iomem_wstrb SHALL stay stable while iomem_valid is high.
REQ-023 iomem_ready sampled high with iomem_valid: latch iomem_rdata, deassert iomem_valid next cycle, go to RESP; exactly one bus transfer per frame.
REQ-024 Timeout counter SHALL start at 0 when iomem_valid rises, increment each cycle ready is low; reaching TIMEOUT_CYCLES without ready -> deassert valid, RESP with NAK.
REQ-025 Ready arriving on the same cycle the count reaches TIMEOUT_CYCLES SHALL count as success.
REQ-026 RESP success write: send 0x06. Success read: send 0x06 then rdata 4 bytes MSB first. Timeout (either op): send 0x15 only.
REQ-027 tx_valid SHALL hold with tx_data stable until accepted; next byte presented the cycle after acceptance; back-to-back tx_ready gives one byte per cycle.
REQ-028 After the last response byte is accepted -> IDLE same edge.
REQ-029 rx_valid in BUS or RESP SHALL drop the byte, set overrun; overrun clears only on reset.
REQ-030 Incomplete frames SHALL wait indefinitely in ADDR/DATA; no inter-byte timeout.
REQ-031 iomem_addr SHALL be passed unmodified; no alignment check, no address decode.

Reset
REQ-032 resetn low SHALL immediately force IDLE, iomem_valid=0, tx_valid=0, overrun=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, tx_data=0, counters=0.
REQ-033 Reset during BUS SHALL drop iomem_valid asynchronously; no response byte after release.
REQ-034 First rx byte accepted SHALL be on the first clk edge after resetn deasserts.

Verification
REQ-035 Write: rx 57 05 00 00 10 DE AD BE EF, ready after 2 cycles -> one transfer addr=0x0500_0010, wdata=0xDEADBEEF, wstrb=F; tx 06.
REQ-036 Read: rx 52 03 00 00 04, ready with rdata=0x1234_5678 -> wstrb=0, tx 06 12 34 56 78 in order; tx_ready stalls 3 cycles mid-stream, data held.
REQ-037 Timeout: TIMEOUT_CYCLES=8, read with ready never high -> valid high exactly 8 cycles, tx 15 only; ready at cycle 8 -> success path.
REQ-038 Unknown cmd: rx 0x41 -> tx 3F, no iomem_valid, back to IDLE.
REQ-039 Overrun: rx byte during BUS -> overrun=1, frame result unaffected, next frame works, overrun stays 1.
REQ-040 Reset mid-BUS: resetn low while iomem_valid high -> all outputs to reset values, no tx; following write frame completes normally.
